// File: rtl/tt_trace_capture.sv
// tt_trace_capture
//   Trace recorder for the TinyTapeout user-project harness. Watches CHANNELS
//   probe buses and, whenever any probed bit changes during capture, pushes
//   {timestamp, probe vector} into an on-chip FIFO. The FIFO is drained through
//   a valid/ready read port that works in every state.
//
//   Optional feature: define TRACE_TRIGGER_EN to add trig_value/trig_mask and
//   a WAIT_TRIG state that holds off capture until channel 0 matches.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   arm        pulse: flush FIFO, clear overflow, (re)start capture
//   stop       pulse: end capture (ignored in IDLE/DONE)
//   probe      observed buses, channel 0 in the LSBs
//   rd_data    {ts, probe} of the oldest entry (0 when empty)
//   rd_valid   FIFO not empty
//   rd_ready   consumer accepts rd_data
//   count      entries held
//   overflow   sticky: a change was dropped because the FIFO was full
//   state      IDLE=0 WAIT_TRIG=1 CAPTURE=2 DONE=3
//   trig_value channel-0 trigger pattern     (TRACE_TRIGGER_EN only)
//   trig_mask  channel-0 trigger bit enables (TRACE_TRIGGER_EN only)
//
// State      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | after reset, nothing recorded
// WAIT_TRIG  | armed, waiting for the channel-0 trigger match
// CAPTURE    | recording probe changes with a running timestamp
// DONE       | capture ended by stop or by a full FIFO; FIFO still drains

module tt_trace_capture #(
    parameter int WIDTH        = 8,
    parameter int CHANNELS     = 3,
    parameter int DEPTH        = 16,
    parameter int TS_W         = 16,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arm,
    input  logic                           stop,
    input  logic [CHANNELS*WIDTH-1:0]      probe,
    output logic [TS_W+CHANNELS*WIDTH-1:0] rd_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           overflow,
    output logic [1:0]                     state
`ifdef TRACE_TRIGGER_EN
    ,
    input  logic [WIDTH-1:0]               trig_value,
    input  logic [WIDTH-1:0]               trig_mask
`endif
);

    localparam int PW = CHANNELS * WIDTH;
    localparam int DW = TS_W + PW;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

`ifdef TRACE_TRIGGER_EN
    localparam state_t ARM_STATE = ST_WAIT_TRIG;
`else
    localparam state_t ARM_STATE = ST_CAPTURE;
`endif

    state_t          state_q;
    logic [TS_W-1:0] ts_q;
    logic [PW-1:0]   prev_q;
    logic            first_q;
    logic            overflow_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_nxt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [DW-1:0]   mem [DEPTH];

    logic trig_hit;
    logic wr_req;
    logic full;
    logic pop;
    logic push;
    logic drop;

`ifdef TRACE_TRIGGER_EN
    assign trig_hit = ((probe[WIDTH-1:0] ^ trig_value) & trig_mask) == '0;
`else
    assign trig_hit = 1'b0;
`endif

    assign full     = (count_q == FULL_CNT);
    assign rd_valid = (count_q != '0);

    // arm flushes the FIFO, so nothing is pushed or popped on an arm edge.
    // A stop edge ends capture without recording that cycle's sample.
    always_comb begin
        wr_req = 1'b0;
        if (!arm && !stop) begin
            case (state_q)
                ST_CAPTURE:   wr_req = first_q || (probe != prev_q);
                // The hit cycle doubles as the first capture cycle (ts = 0).
                ST_WAIT_TRIG: wr_req = trig_hit;
                default:      wr_req = 1'b0;
            endcase
        end
    end

    assign pop  = rd_valid && rd_ready && !arm;
    // When full, a push is only accepted if a pop frees a slot on the same edge.
    assign push = wr_req && (!full || pop);
    assign drop = wr_req && full && !pop;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            prev_q     <= '0;
            first_q    <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            prev_q <= probe;
            if (arm) begin
                state_q    <= ARM_STATE;
                ts_q       <= '0;
                first_q    <= 1'b1;
                overflow_q <= 1'b0;
                count_q    <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else begin
                count_q <= count_nxt;
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
                case (state_q)
                    ST_WAIT_TRIG: begin
                        if (stop) begin
                            state_q <= ST_DONE;
                        end else if (trig_hit) begin
                            // Entry 0 was taken at ts=0 this edge; keep counting from 1.
                            state_q <= ST_CAPTURE;
                            ts_q    <= TS_W'(1);
                            first_q <= 1'b0;
                            if ((STOP_ON_FULL != 0) && (count_nxt == FULL_CNT)) begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        first_q <= 1'b0;
                        if (ts_q != '1) begin
                            ts_q <= ts_q + 1'b1;
                        end
                        if (stop || ((STOP_ON_FULL != 0) && (count_nxt == FULL_CNT))) begin
                            state_q <= ST_DONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Storage needs no reset: rd_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ts_q, probe};
        end
    end

    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign state    = state_q;

endmodule

// File: tb/tb_tt_trace_capture.sv
module tb_tt_trace_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        stop;
    logic [23:0] probe;
    logic        rd_ready0;
    logic        rd_ready1;
    logic [39:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic [4:0]  count0, count1;
    logic        overflow0, overflow1;
    logic [1:0]  state0, state1;
    logic [7:0]  trig_value;
    logic [7:0]  trig_mask;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // dut0 keeps running when full; dut1 stops when full. Both see the same stimulus.
    tt_trace_capture #(.STOP_ON_FULL(0)) dut0 (
        .clk(clk), .rst(rst), .arm(arm), .stop(stop), .probe(probe),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready0),
        .count(count0), .overflow(overflow0), .state(state0)
`ifdef TRACE_TRIGGER_EN
        , .trig_value(trig_value), .trig_mask(trig_mask)
`endif
    );

    tt_trace_capture #(.STOP_ON_FULL(1)) dut1 (
        .clk(clk), .rst(rst), .arm(arm), .stop(stop), .probe(probe),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready1),
        .count(count1), .overflow(overflow1), .state(state1)
`ifdef TRACE_TRIGGER_EN
        , .trig_value(trig_value), .trig_mask(trig_mask)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] entry(input int ts, input int p);
        logic [15:0] t;
        logic [23:0] v;
        t = 16'(ts);
        v = 24'(p);
        return {24'd0, t, v};
    endfunction

    initial begin
        rst = 1'b1; arm = 1'b0; stop = 1'b0; probe = '0;
        rd_ready0 = 1'b0; rd_ready1 = 1'b0;
        trig_value = '0; trig_mask = '0;
        step();
        step();
        check_eq("rst_state", state0, 0);
        check_eq("rst_count", count0, 0);
        check_eq("rst_valid", rd_valid0, 0);
        check_eq("rst_data", rd_data0, 0);
        rst = 1'b0;
        step();

        // stop is ignored in IDLE
        stop = 1'b1; step(); stop = 1'b0;
        check_eq("idle_stop_state", state0, 0);

        // 1: reset mid-capture
        arm = 1'b1; step(); arm = 1'b0;
        probe = 24'h1; step();
        probe = 24'h2; step();
        probe = 24'h3; step();
        check_eq("t1_count_pre", count0, 3);
        rst = 1'b1;
        #1;
        check_eq("t1_count", count0, 0);
        check_eq("t1_state", state0, 0);
        check_eq("t1_valid", rd_valid0, 0);
        check_eq("t1_ovf", overflow0, 0);
        probe = '0;
        step();
        rst = 1'b0;
        step();

        // 2: basic trace
        arm = 1'b1; step(); arm = 1'b0;
        repeat (5) step();
        probe = 24'h0000A5; step();
        repeat (3) step();
        stop = 1'b1; step(); stop = 1'b0;
        check_eq("t2_state", state0, 3);
        check_eq("t2_count", count0, 2);
        check_eq("t2_e0", rd_data0, entry(0, 0));
        step(); step();
        check_eq("t2_hold", rd_data0, entry(0, 0));
        rd_ready0 = 1'b1;
        step();
        check_eq("t2_e1", rd_data0, entry(5, 'hA5));
        step();
        rd_ready0 = 1'b0;
        check_eq("t2_empty", rd_valid0, 0);

        // 3 + 4: 20 changes; dut0 overflows, dut1 stops at 16
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            probe = 24'(i + 1);
            step();
            if (i == 14) check_eq("t4_state_15", state1, 2);
            if (i == 15) begin
                check_eq("t4_state_16", state1, 3);
                check_eq("t4_count_16", count1, 16);
            end
        end
        check_eq("t3_count", count0, 16);
        check_eq("t3_ovf", overflow0, 1);
        check_eq("t4_count", count1, 16);
        check_eq("t4_ovf", overflow1, 0);
        check_eq("t4_state", state1, 3);
        rd_ready0 = 1'b1; rd_ready1 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check_eq($sformatf("t3_e%0d", k), rd_data0, entry(k, k + 1));
            check_eq($sformatf("t4_e%0d", k), rd_data1, entry(k, k + 1));
            step();
        end
        rd_ready0 = 1'b0; rd_ready1 = 1'b0;
        check_eq("t3_drained", count0, 0);
        check_eq("t3_ovf_sticky", overflow0, 1);
        arm = 1'b1; step(); arm = 1'b0;
        check_eq("t3_arm_ovf", overflow0, 0);
        check_eq("t3_arm_count", count0, 0);
        stop = 1'b1; step(); stop = 1'b0;
        check_eq("t3_stop_count", count0, 0);
        check_eq("t3_stop_state", state0, 3);

        // 5: full plus change with a simultaneous pop
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 16; i++) begin
            probe = 24'(32'h100 + i);
            step();
        end
        check_eq("t5_full", count0, 16);
        probe = 24'h1FF; rd_ready0 = 1'b1;
        step();
        check_eq("t5_count", count0, 16);
        check_eq("t5_ovf", overflow0, 0);
        for (int k = 1; k < 16; k++) begin
            check_eq($sformatf("t5_e%0d", k), rd_data0, entry(k, 'h100 + k));
            step();
        end
        check_eq("t5_last", rd_data0, entry(16, 'h1FF));
        step();
        rd_ready0 = 1'b0;
        check_eq("t5_empty", rd_valid0, 0);
        stop = 1'b1; step(); stop = 1'b0;

`ifdef TRACE_TRIGGER_EN
        // 6: trigger on channel 0
        trig_value = 8'h3C; trig_mask = 8'hFF; probe = '0;
        arm = 1'b1; step(); arm = 1'b0;
        check_eq("t6_wait", state0, 1);
        repeat (3) step();
        check_eq("t6_still_wait", state0, 1);
        check_eq("t6_no_entry", count0, 0);
        probe = 24'h00003C;
        step();
        check_eq("t6_capture", state0, 2);
        check_eq("t6_count", count0, 1);
        check_eq("t6_e0", rd_data0, entry(0, 'h3C));
        stop = 1'b1; step(); stop = 1'b0;
        trig_mask = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
